// File: rtl/mips_mem_arbiter_pkg.sv
// mips_arb_pkg
// Shared definitions for the MIPS32 single-port memory arbiter:
//   - default address/data widths shared with the mips_32 core
//   - owner encoding (which requester performed an access)
//   - width of the IF starvation counter
package mips_arb_pkg;

  localparam int MIPS_ADDR_W = 10;
  localparam int MIPS_DATA_W = 32;

  // Starvation counter width; STARVE_MAX must fit (1..15)
  localparam int SC_W = 4;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_LD   = 2'd1;
  localparam owner_t OWN_DM   = 2'd2;
  localparam owner_t OWN_IF   = 2'd3;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if
// Bundles the three requester ports (loader, data port, instruction fetch),
// the core halted flag, the shared read data, the memory-side strobes and
// the registered owner.
//   master : requester / memory side (drives requests and mem_rdata)
//   slave  : the arbiter (drives grants, rvalids, rdata, mem_*, owner)
interface mips_mem_arbiter_if
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W
);

  logic              halted;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  owner_t            owner;

  modport master (
    output halted,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid,
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );

  modport slave (
    input  halted,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid,
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

endinterface

// File: rtl/mips_mem_arbiter_starve_cnt.sv
// mips_starve_cnt
// Saturating counter of consecutive cycles in which instruction fetch
// wanted memory but was denied.
//   clk1, rst : clock and synchronous active-high reset
//   inc       : count one more denied cycle (saturates at STARVE_MAX)
//   clr       : return to zero (fetch granted or not requesting); wins over inc
//   count     : current count
//   sat       : count has reached STARVE_MAX
module mips_starve_cnt
  import mips_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            inc,
  input  logic            clr,
  output logic [SC_W-1:0] count,
  output logic            sat
);

  localparam logic [SC_W-1:0] MAX_C = SC_W'(STARVE_MAX);

  // Count register: clear has priority, increment stops at the limit
  always_ff @(posedge clk1) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == MAX_C);

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one synchronous-read word memory between the program loader (LD),
// the MEM-stage data port (DM) and the IF-stage fetch (IF).
// Priority is LD > DM > IF, except that a fetch starved for STARVE_MAX
// cycles is lifted above DM. The loader is never overridden.
//   clk1, rst : clock and synchronous active-high reset
//   bus       : requester ports, grants, rvalids, shared rdata,
//               memory strobes and the registered owner (slave modport)
// Grants and mem_* are combinational; rvalids and owner are registered.
module mips_mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W     = MIPS_ADDR_W,
  parameter int DATA_W     = MIPS_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk1,
  input  logic               rst,
  mips_mem_arbiter_if.slave  bus
);

  logic            if_eff;
  logic            starve;
  logic [SC_W-1:0] sc;
  owner_t          win;
  owner_t          owner_q;
  logic            ld_rv_q;
  logic            dm_rv_q;
  logic            if_rv_q;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;

  // A halted core cannot fetch, so its request is masked before arbitration
  assign if_eff = bus.if_req & ~bus.halted;

  mips_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk1  (clk1),
    .rst   (rst),
    .inc   (if_eff & ~bus.if_gnt),
    .clr   (bus.if_gnt | ~if_eff),
    .count (sc),
    .sat   (starve)
  );

  // Winner selection and memory-side mux; the loader always wins so it
  // keeps memory for its whole load sequence
  always_comb begin
    win       = OWN_NONE;
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    if (bus.ld_req) begin
      win = OWN_LD;
    end else if (if_eff && starve) begin
      win = OWN_IF;
    end else if (bus.dm_req) begin
      win = OWN_DM;
    end else if (if_eff) begin
      win = OWN_IF;
    end
    unique case (win)
      OWN_LD: begin
        addr_sel  = bus.ld_addr;
        wdata_sel = bus.ld_wdata;
        we_sel    = bus.ld_we;
      end
      OWN_DM: begin
        addr_sel  = bus.dm_addr;
        wdata_sel = bus.dm_wdata;
        we_sel    = bus.dm_we;
      end
      OWN_IF: begin
        addr_sel  = bus.if_addr;
      end
      default: begin
        addr_sel  = '0;
      end
    endcase
  end

  assign bus.ld_gnt    = (win == OWN_LD);
  assign bus.dm_gnt    = (win == OWN_DM);
  assign bus.if_gnt    = (win == OWN_IF);
  assign bus.mem_en    = (win != OWN_NONE);
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  // Read grants return data next cycle; writes never raise an rvalid.
  // owner records who used memory in the cycle just ended.
  always_ff @(posedge clk1) begin
    if (rst) begin
      ld_rv_q <= 1'b0;
      dm_rv_q <= 1'b0;
      if_rv_q <= 1'b0;
      owner_q <= OWN_NONE;
    end else begin
      ld_rv_q <= bus.ld_gnt & ~bus.ld_we;
      dm_rv_q <= bus.dm_gnt & ~bus.dm_we;
      if_rv_q <= bus.if_gnt;
      owner_q <= win;
    end
  end

  // Reset in the return cycle of a read cancels that read's rvalid at once
  assign bus.ld_rvalid = ld_rv_q & ~rst;
  assign bus.dm_rvalid = dm_rv_q & ~rst;
  assign bus.if_rvalid = if_rv_q & ~rst;
  assign bus.owner     = owner_q;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
// Directed bench for mips_mem_arbiter: drives the requester ports through
// the interface, models the synchronous word memory, and compares outputs
// against hand-computed values.
module tb_mips_mem_arbiter;
  import mips_arb_pkg::*;

  logic clk1;
  logic rst;
  int   errCount;
  int   checkCount;

  logic [31:0] mem [1024];

  mips_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mips_mem_arbiter #(
    .ADDR_W     (10),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  // 10 ns clock
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Synchronous-read memory driven by the arbiter's strobes
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive all requester inputs for one cycle, then let combinational logic settle
  task automatic applyStimulus(
    input logic ld_r, input logic ld_w, input logic [9:0] ld_a, input logic [31:0] ld_d,
    input logic dm_r, input logic dm_w, input logic [9:0] dm_a, input logic [31:0] dm_d,
    input logic if_r, input logic [9:0] if_a, input logic halt);
    bus.ld_req   = ld_r;
    bus.ld_we    = ld_w;
    bus.ld_addr  = ld_a;
    bus.ld_wdata = ld_d;
    bus.dm_req   = dm_r;
    bus.dm_we    = dm_w;
    bus.dm_addr  = dm_a;
    bus.dm_wdata = dm_d;
    bus.if_req   = if_r;
    bus.if_addr  = if_a;
    bus.halted   = halt;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nextCycle();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    foreach (mem[i]) mem[i] = 32'd0;
    bus.mem_rdata = 32'd0;
    rst = 1'b1;
    idle();
    nextCycle();
    nextCycle();

    // Reset state
    checkOutput("rst_ld_rvalid", {31'd0, bus.ld_rvalid}, 0);
    checkOutput("rst_dm_rvalid", {31'd0, bus.dm_rvalid}, 0);
    checkOutput("rst_if_rvalid", {31'd0, bus.if_rvalid}, 0);
    checkOutput("rst_owner", {30'd0, bus.owner}, 0);
    checkOutput("rst_sc", {28'd0, dut.sc}, 0);
    checkOutput("rst_mem_en", {31'd0, bus.mem_en}, 0);
    rst = 1'b0;
    nextCycle();

    // Loader write 85 -> 120, then loader read of 120
    applyStimulus(1, 1, 120, 85, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ldw_gnt", {31'd0, bus.ld_gnt}, 1);
    checkOutput("ldw_mem_en", {31'd0, bus.mem_en}, 1);
    checkOutput("ldw_mem_we", {31'd0, bus.mem_we}, 1);
    checkOutput("ldw_mem_addr", {22'd0, bus.mem_addr}, 120);
    checkOutput("ldw_mem_wdata", bus.mem_wdata, 85);
    nextCycle();
    applyStimulus(1, 0, 120, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ldr_gnt", {31'd0, bus.ld_gnt}, 1);
    checkOutput("ldr_mem_we", {31'd0, bus.mem_we}, 0);
    checkOutput("ldw_no_rvalid", {31'd0, bus.ld_rvalid}, 0);
    checkOutput("ldw_owner", {30'd0, bus.owner}, 1);
    nextCycle();
    idle();
    checkOutput("ldr_rvalid", {31'd0, bus.ld_rvalid}, 1);
    checkOutput("ldr_rdata", bus.rdata, 85);
    checkOutput("ldr_owner", {30'd0, bus.owner}, 1);
    checkOutput("idle_mem_en", {31'd0, bus.mem_en}, 0);
    checkOutput("idle_mem_addr", {22'd0, bus.mem_addr}, 0);
    nextCycle();
    checkOutput("ldr_rvalid_once", {31'd0, bus.ld_rvalid}, 0);

    // DM read of 120 beats IF read of 0 while sc < 4
    applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 0);
    checkOutput("dm_vs_if_dm_gnt", {31'd0, bus.dm_gnt}, 1);
    checkOutput("dm_vs_if_if_gnt", {31'd0, bus.if_gnt}, 0);
    checkOutput("dm_vs_if_addr", {22'd0, bus.mem_addr}, 120);
    nextCycle();
    idle();
    checkOutput("dm_rvalid", {31'd0, bus.dm_rvalid}, 1);
    checkOutput("dm_rdata", bus.rdata, 85);
    checkOutput("dm_owner", {30'd0, bus.owner}, 2);
    checkOutput("dm_vs_if_sc", {28'd0, dut.sc}, 1);
    nextCycle();

    // DM and IF both continuous: IF wins on the 5th cycle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 0);
      checkOutput($sformatf("starve_sc_%0d", i), {28'd0, dut.sc}, (i < 5) ? i : 0);
      checkOutput($sformatf("starve_if_gnt_%0d", i), {31'd0, bus.if_gnt}, (i == 4) ? 1 : 0);
      checkOutput($sformatf("starve_dm_gnt_%0d", i), {31'd0, bus.dm_gnt}, (i == 4) ? 0 : 1);
      if (i == 5) begin
        checkOutput("starve_if_rvalid", {31'd0, bus.if_rvalid}, 1);
        checkOutput("starve_owner", {30'd0, bus.owner}, 3);
      end
      nextCycle();
    end
    idle();
    nextCycle();

    // Halted core: fetch requests are ignored
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
      checkOutput($sformatf("halt_if_gnt_%0d", i), {31'd0, bus.if_gnt}, 0);
      checkOutput($sformatf("halt_mem_en_%0d", i), {31'd0, bus.mem_en}, 0);
      checkOutput($sformatf("halt_sc_%0d", i), {28'd0, dut.sc}, 0);
      nextCycle();
    end
    idle();
    nextCycle();

    // Loader holds memory; sc saturates at 4 and IF then jumps DM
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 120, 0, 1, 0, 120, 0, 1, 0, 0);
      checkOutput($sformatf("ldhold_ld_gnt_%0d", i), {31'd0, bus.ld_gnt}, 1);
      checkOutput($sformatf("ldhold_dm_gnt_%0d", i), {31'd0, bus.dm_gnt}, 0);
      checkOutput($sformatf("ldhold_if_gnt_%0d", i), {31'd0, bus.if_gnt}, 0);
      checkOutput($sformatf("ldhold_sc_%0d", i), {28'd0, dut.sc}, (i < 4) ? i : 4);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 0);
    checkOutput("ldrel_if_gnt", {31'd0, bus.if_gnt}, 1);
    checkOutput("ldrel_dm_gnt", {31'd0, bus.dm_gnt}, 0);
    checkOutput("ldrel_sc", {28'd0, dut.sc}, 4);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 0);
    checkOutput("ldrel2_dm_gnt", {31'd0, bus.dm_gnt}, 1);
    checkOutput("ldrel2_sc", {28'd0, dut.sc}, 0);
    nextCycle();
    idle();
    nextCycle();

    // halted rising while IF is starving clears sc next cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 1, 0, 1);
    checkOutput("haltrise_sc_before", {28'd0, dut.sc}, 3);
    checkOutput("haltrise_if_gnt", {31'd0, bus.if_gnt}, 0);
    checkOutput("haltrise_dm_gnt", {31'd0, bus.dm_gnt}, 1);
    nextCycle();
    idle();
    checkOutput("haltrise_sc_after", {28'd0, dut.sc}, 0);
    nextCycle();

    // Reset in the cycle after a DM read grant
    applyStimulus(0, 0, 0, 0, 1, 0, 120, 0, 0, 0, 0);
    checkOutput("rstrd_dm_gnt", {31'd0, bus.dm_gnt}, 1);
    nextCycle();
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rstrd_rvalid_in_rst", {31'd0, bus.dm_rvalid}, 0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rstrd_rvalid_after", {31'd0, bus.dm_rvalid}, 0);
    checkOutput("rstrd_owner", {30'd0, bus.owner}, 0);
    checkOutput("rstrd_sc", {28'd0, dut.sc}, 0);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter for the MIPS32 core. It shares one synchronous-read word memory among three requesters: the program loader (LD), the MEM-stage data port (DM, for LW/SW) and the IF-stage instruction fetch (IF). It sits between the pipeline/loader and the memory array and replaces hierarchical preloading of memory. Arbitration is fixed-priority with an anti-starvation override for instruction fetch, and IF grants are gated by the core's halted flag.

## Interface
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied IF cycles before IF is promoted above DM (range 1..15)

- clk1  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  core HALTED flag; while 1, if_req is ignored
- ld_req / ld_we  in  1 / 1  loader request / write enable
- ld_addr / ld_wdata  in  ADDR_W / DATA_W  loader address / write data
- ld_gnt / ld_rvalid  out  1 / 1  loader granted this cycle / read data valid
- dm_req / dm_we  in  1 / 1  data-port request / write enable
- dm_addr / dm_wdata  in  ADDR_W / DATA_W  data address / write data
- dm_gnt / dm_rvalid  out  1 / 1  data-port grant / read data valid
- if_req / if_addr  in  1 / ADDR_W  fetch request (read only) / fetch address
- if_gnt / if_rvalid  out  1 / 1  fetch grant / fetch data valid
- rdata  out  DATA_W  read data, shared by all requesters; qualified by the *_rvalid signals
- mem_en / mem_we  out  1 / 1  memory access strobe / write strobe
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- owner  out  2  requester that performed last cycle's access (registered)

## Operation
- At most one grant per cycle. Grants and mem_* are combinational from the current-cycle requests.
- Default priority: LD > DM > IF.
- Effective IF request = if_req & ~halted.
- Starvation counter sc (4 bits):
  - Increments when the effective IF request is denied.
  - Saturates at STARVE_MAX.
  - Clears to 0 on if_gnt, or when the effective IF request is low.
- When sc == STARVE_MAX, priority becomes LD > IF > DM for that cycle. LD is never overridden.
- While ld_req = 1, DM and IF are never granted, so the loader owns memory for the whole load sequence.
- Granted access:
  - mem_en = 1.
  - mem_addr and mem_wdata come from the winner.
  - mem_we = winner's we. For IF, mem_we = 0.
- No request: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- A read grant sets the winner's rvalid on the next cycle. rdata = mem_rdata (passthrough).
- Writes never produce an rvalid.
- owner encoding: NONE = 0, LD = 1, DM = 2, IF = 3. owner is registered from the cycle's winner.
- Requesters hold req/addr/data until their gnt is seen. The arbiter does not queue requests.

## Timing
- Reset values: sc = 0, all *_rvalid = 0, owner = 0. Combinational outputs are 0 when no request is present.
- Read latency: gnt in cycle N, then *_rvalid = 1 and rdata valid in cycle N+1, for exactly one cycle.
- Write: memory is updated at the edge ending cycle N.
- Back-to-back grants to the same requester are allowed every cycle. Full throughput is one access per cycle.
- rst asserted in the cycle after a read grant: the rvalid is suppressed (0) and sc returns to 0. Grants remain combinational during rst and mem_en follows requests. Requesters must deassert their requests during reset.
- halted rising while IF is starving: sc clears to 0 in the next cycle. A fetch read granted in the same cycle as halted rising still returns its if_rvalid.
- All three requests simultaneous with sc < STARVE_MAX: LD wins. With ld_req = 0: DM wins until sc saturates.

## Structure
- Package mips_arb_pkg holds:
  - owner encoding localparams OWN_NONE, OWN_LD, OWN_DM, OWN_IF
  - a 2-bit owner_t typedef
  - default ADDR_W / DATA_W constants shared with mips_32
- One sub-module, mips_starve_cnt: a saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX.
- The top level contains the priority mux, the grant logic and the rvalid/owner registers.

## Test plan
- Loader write of 85 to address 120, then loader read of 120: ld_gnt = 1 in both cycles, ld_rvalid = 1 and rdata = 85 one cycle after the read, owner = 1.
- Simultaneous DM read of 120 and IF read of 0, with sc < 4: dm_gnt = 1, if_gnt = 0, dm_rvalid next cycle with rdata = 85, sc = 1.
- DM requests continuously and IF requests continuously, STARVE_MAX = 4: IF is denied 4 cycles and granted in the 5th. The DM grant resumes in the 6th and sc returns to 0.
- halted = 1 with if_req = 1 for 10 cycles, no other requests: if_gnt = 0, mem_en = 0, sc stays 0.
- ld_req held during DM and IF requests: only ld_gnt asserts, and sc reaches and holds 4. After ld_req drops, IF is granted before DM.
- rst pulsed in the cycle after a DM read grant: dm_rvalid = 0, owner = 0, sc = 0 in the following cycle.
